// File: rtl/instr_trace_encoder.sv
// instr_trace_encoder
// Recovers the 6-bit opcode from the execute-stage control bundle and
// queues {pc, opcode, illegal} trace records in a small FIFO drained over
// a valid/ready handshake. The pipeline is never stalled. When the FIFO is
// full and nothing is leaving, the record is dropped and counted instead.
//
// Build option: define TRACE_SKIP_NOP_EN to keep NOP bundles out of the
// trace entirely. NOPs are then not retired and can never cause a drop.
// Without the macro, NOPs are recorded like any other instruction.

module instr_trace_encoder #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [3:0]       Exe_Cmd,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             WB_Enable,
    input  logic             is_immediate,
    input  logic [1:0]       Branch_Type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       out_opcode,
    output logic             out_illegal,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // {illegal, opcode}. An unmatched bundle reads back as opcode 3F with illegal set.
    logic [6:0] enc_code;
    logic       is_nop;
    logic       record_en;

    logic [PC_W-1:0] mem_pc  [DEPTH];
    logic [5:0]      mem_op  [DEPTH];
    logic            mem_ill [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    // Combinational decode of the control bundle back into its opcode.
    always_comb begin
        enc_code = {1'b1, 6'h3F};
        if (Branch_Type != 2'b00) begin
            // Branches carry no memory access or writeback, and their ALU command is don't-care.
            if (!mem_read && !mem_write && !WB_Enable) begin
                case (Branch_Type)
                    2'b01:   enc_code = {1'b0, 6'd40};
                    2'b10:   enc_code = {1'b0, 6'd41};
                    default: enc_code = {1'b0, 6'd42};
                endcase
            end
        end else if (!mem_read && !mem_write && !WB_Enable) begin
            enc_code = 7'd0;
        end else if (WB_Enable && !mem_read && !mem_write && !is_immediate) begin
            case (Exe_Cmd)
                4'b0000: enc_code = {1'b0, 6'd1};
                4'b0010: enc_code = {1'b0, 6'd3};
                4'b0100: enc_code = {1'b0, 6'd5};
                4'b0101: enc_code = {1'b0, 6'd6};
                4'b0110: enc_code = {1'b0, 6'd7};
                4'b0111: enc_code = {1'b0, 6'd8};
                // SLA and SLL produce identical control words, so they cannot be told apart; report SLA.
                4'b1000: enc_code = {1'b0, 6'd9};
                4'b1001: enc_code = {1'b0, 6'd11};
                4'b1010: enc_code = {1'b0, 6'd12};
                default: enc_code = {1'b1, 6'h3F};
            endcase
        end else if (WB_Enable && !mem_write && is_immediate) begin
            if (!mem_read) begin
                case (Exe_Cmd)
                    4'b0000: enc_code = {1'b0, 6'd32};
                    4'b0010: enc_code = {1'b0, 6'd33};
                    default: enc_code = {1'b1, 6'h3F};
                endcase
            end else if (Exe_Cmd == 4'b0000) begin
                enc_code = {1'b0, 6'd36};
            end
        end else if (mem_write && !mem_read && !WB_Enable && is_immediate
                     && Exe_Cmd == 4'b0000) begin
            enc_code = {1'b0, 6'd37};
        end
    end

    assign is_nop = (enc_code == 7'd0);

`ifdef TRACE_SKIP_NOP_EN
    assign record_en = in_valid && !is_nop;
`else
    assign record_en = in_valid;
`endif

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign pop    = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push   = record_en && (!full || pop);
    assign drop   = record_en && full && !pop;

    // Record storage. Contents need no reset because the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc[wr_idx]  <= in_pc;
            mem_op[wr_idx]  <= enc_code[5:0];
            mem_ill[wr_idx] <= enc_code[6];
        end
    end

    // Pointer update. Both pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Retired count wraps. Drop count saturates. Overflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) retired_cnt <= retired_cnt + CNT_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    // Head entry drives the outputs directly. Zeros are forced while empty so reset values are clean.
    always_comb begin
        out_valid   = !empty;
        out_pc      = '0;
        out_opcode  = '0;
        out_illegal = 1'b0;
        if (!empty) begin
            out_pc      = mem_pc[rd_idx];
            out_opcode  = mem_op[rd_idx];
            out_illegal = mem_ill[rd_idx];
        end
    end

endmodule

// File: doc/instr_trace_encoder.md
Name: instr_trace_encoder

Overview:
- Sits beside the pipeline at the execute stage and turns each instruction's decoded control bundle back into its 6-bit opcode.
- Pushes {pc, opcode, illegal} records into a small FIFO that drains to a debug/trace consumer over a valid/ready handshake.
- Is never allowed to stall the pipeline: when the FIFO is full, records are dropped and counted.

Parameters:
- PC_W, 32, width of captured PC tag.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the retired and dropped counters.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a control bundle is present this cycle
- in_pc  in  PC_W  PC of that instruction
- Exe_Cmd  in  4  ALU command
- mem_read  in  1  load flag
- mem_write  in  1  store flag
- WB_Enable  in  1  register writeback flag
- is_immediate  in  1  immediate operand flag
- Branch_Type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head
- out_pc  out  PC_W  head PC
- out_opcode  out  6  head opcode
- out_illegal  out  1  head bundle matched no opcode
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  CNT_W  dropped records, saturating
- retired_cnt  out  CNT_W  records pushed, wrapping

Behaviour:
- Reset: the clock is clk and the reset is rst, synchronous and active-high. On reset the FIFO empties, out_valid=0, out_pc=0, out_opcode=0, out_illegal=0, overflow=0, drop_cnt=0, retired_cnt=0.
- Encoding is combinational; the tuple is {Exe_Cmd, mr, mw, wb, imm, BT}.
  - BT=01 with mr=mw=wb=0 -> 40. BT=10 -> 41. BT=11 -> 42. Exe_Cmd is ignored in all three.
  - BT=00, mr=mw=wb=0 -> NOP (0); Exe_Cmd and imm are ignored.
  - wb=1, imm=0, mr=mw=0, by Exe_Cmd: 0000 ->1, 0010 ->3, 0100 ->5, 0101 ->6, 0110 ->7, 0111 ->8, 1000 ->9, 1001 ->11, 1010 ->12.
  - SLA and SLL share one control word; it is always encoded as 9.
  - wb=1, imm=1: Exe_Cmd 0000 -> 32 (ADDI); 0010 -> 33 (SUBI); 0000 with mr=1 -> 36 (LD).
  - mw=1, imm=1, wb=0, mr=0, Exe_Cmd 0000 -> 37 (ST).
  - Any other tuple -> opcode 6'h3F, illegal=1. This includes mr&mw, branch with wb/mr/mw, and a shift with imm.
- FIFO push: on in_valid when not full, store {in_pc, opcode, illegal} and increment retired_cnt (wraps).
- FIFO pop: on out_valid && out_ready, advance the head.
- Full-drop: in_valid while full and no pop this cycle -> record discarded, overflow set, drop_cnt+1, saturating at all-ones. retired_cnt is unchanged.
- Full with simultaneous pop and push: the push is accepted, occupancy is unchanged, nothing is dropped.
- Empty with simultaneous push: no bypass. out_valid rises the cycle after the push, so latency is 1 cycle from in_valid to out_valid.
- Output stability: out_* are driven directly from the head entry and stay stable while out_valid && !out_ready.
- Pointers: read/write pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the rest are equal; empty when equal.
- overflow clears only on rst.
- Reset mid-stream: all entries are lost and out_valid=0 the next cycle regardless of out_ready.

Optional Feature:
- TRACE_SKIP_NOP_EN defined: bundles encoding to NOP (opcode 0, illegal=0) are not pushed. They do not count in retired_cnt and never cause drops.
- Undefined: NOPs are pushed like any other record.

Test Plan:
- Reset, then one bundle {0000,0,0,1,0,00}, pc=0x100, out_ready=1 -> next cycle out_valid=1, opcode=1, pc=0x100, illegal=0; retired_cnt=1.
- Sweep every legal opcode: LD {0000,1,0,1,1,00} -> 36; ST {0000,0,1,0,1,00} -> 37; BNE {xxxx,0,0,0,0,10} -> 41; shift 1000 -> 9. Records come out in push order.
- Illegal bundle {0000,1,1,1,1,00} -> opcode 0x3F, illegal=1.
- Hold out_ready=0 and push DEPTH+3 bundles -> DEPTH records retained; drop_cnt=3, overflow=1, retired_cnt=DEPTH. Then drain in order; out_valid falls after DEPTH pops.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> no drop, occupancy stays DEPTH, drop_cnt unchanged.
- Assert rst with 4 entries queued -> out_valid=0, counters=0, overflow=0 next cycle. With TRACE_SKIP_NOP_EN, pushing 3 NOPs + 1 ADD -> exactly 1 record, retired_cnt=1.
